regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback requesters (ALU result, load data, ...).
- Round-robin arbitration, one grant per cycle.
- Valid/ready handshake per requester.
- Registered writeback stage driving the register file's reg_write, rd_addr and rd_data.
- Read-hazard flags so decode can stall when a source register has a write in flight.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..4).
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width (32 registers, x0 hardwired zero).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (sampled on the rising edge of clk; 0 = reset).
- hold  input  1  freezes arbitration; no grants while 1.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed destination addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- req_ready  output  NUM_REQ  one-hot grant; the transfer occurs when valid & ready.
- reg_write  output  1  to register file write enable.
- rd_addr  output  ADDR_WIDTH  to register file destination.
- rd_data  output  DATA_WIDTH  to register file write data.
- rs1_addr  input  ADDR_WIDTH  decode source 1 query.
- rs2_addr  input  ADDR_WIDTH  decode source 2 query.
- hazard_rs1  output  1  source 1 has a pending write.
- hazard_rs2  output  1  source 2 has a pending write.

Behaviour:
- State:
  - rr_ptr (clog2 NUM_REQ bits).
  - Writeback stage: wb_valid, wb_addr, wb_data.
- Reset (reset==0 at an edge):
  - rr_ptr=0, wb_valid=0, wb_addr=0, wb_data=0.
  - Therefore reg_write=0, rd_addr=0, rd_data=0.
  - req_ready forced to 0 while reset==0, so no transfer can occur during reset.
- Reset mid-operation: an in-flight wb stage entry is discarded; the register file is not written; requesters keep their valid asserted and are re-arbitrated after release.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first asserted index gets req_ready; the result is one-hot or zero.
  - hold==1 or reset==0 gives req_ready=0.
- Pointer update: on a transfer by requester g, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Handshake:
  - Requesters keep valid, addr and data stable until ready.
  - The arbiter never drops a granted transfer.
  - The wb stage drains every cycle (the register file always accepts), so throughput is one write per cycle and there is no backpressure beyond arbitration.
- Latency:
  - A transfer in cycle N loads the wb stage at edge N.
  - reg_write, rd_addr and rd_data are valid during cycle N+1.
  - The register file commits at edge N+1.
  - If there is no transfer, wb_valid <= 0.
- x0 handling:
  - Requests to address 0 are accepted (ready asserted) and consume the grant.
  - reg_write = wb_valid & (wb_addr != 0).
  - rd_addr and rd_data still reflect the wb stage.
- Hazards: hazard_rsK = (rsK_addr != 0) & (match on any req_valid[i] address OR (wb_valid & wb_addr==rsK_addr)).
  - Purely combinational.
  - Independent of hold.
- Same-address collisions:
  - Two requesters targeting the same register are serialized in grant order; the later grant wins in the register file.
  - The hazard stays asserted until both writes have left the wb stage.
- Fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0 (shared with register_file).
  - NUM_WB_REQ default.
  - Requester index constants WB_ALU=0, WB_LOAD=1.
- One sub-module is natural: rr_arbiter, a generic N-way round-robin grant taking req, ptr and enable, and producing a one-hot grant plus its encoded index. Reused later for memory-port sharing.

Test Plan:
1. Reset: hold reset=0 for 2 cycles while req_valid=2'b11 → req_ready=00, reg_write=0, rd_addr=0, rd_data=0. Release reset → first grant goes to requester 0.
2. Single write: req0 addr=1, data=32'h12345678 valid for 1 cycle (ready=1) → next cycle reg_write=1, rd_addr=1, rd_data=12345678. Register file read of x1 after that edge returns 12345678.
3. Contention: both valid continuously (req0 x2=87654321, req1 x3=0000BEEF) → grants alternate 01,10,01,10 and rd_addr alternates 2,3,2,3.
4. x0 write: req1 addr=0, data=FFFFFFFF → req_ready[1]=1, next cycle reg_write=0, and x0 still reads 0.
5. Hazards: req0 valid addr=5, rs1_addr=5, rs2_addr=0 → hazard_rs1=1, hazard_rs2=0. After the grant, hazard_rs1 stays 1 one more cycle (wb stage), then drops to 0.
6. Hold and reset mid-flight: hold=1 with req0 valid for 3 cycles → no ready, reg_write=0, rr_ptr unchanged. Grant req1 then assert reset=0 next cycle → reg_write stays 0 and the write is dropped.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared constants for the register-file writeback path. The register file
// uses the same address/data widths and the hardwired-zero register index.
// Also holds the default number of writeback requesters, their index
// assignments, and the round-robin pointer advance helper.
// ----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int NUM_WB_REQ = 2;

    // Fixed requester slots on the writeback port.
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1
    } wb_req_e;

    // Round-robin pointer advance: the requester after the winner gets
    // first look next time, wrapping at n.
    function automatic int rr_next(input int granted, input int n);
        return (granted + 1) % n;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_arb.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Generic N-way round-robin grant. The search starts at ptr_i and wraps
// modulo N; the first asserted request wins. Produces a one-hot grant,
// its encoded index and a valid flag. With en_i low nothing is granted.
//
// Ports:
//   req_i         in   N      request vector
//   ptr_i         in   IDX_W  index with highest priority this cycle
//   en_i          in   1      grant enable
//   grant_o       out  N      one-hot grant (or zero)
//   grant_idx_o   out  IDX_W  encoded index of the grant
//   grant_valid_o out  1      a grant was issued
// ----------------------------------------------------------------------------
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int N     = NUM_WB_REQ,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; a path that leaves one unassigned
        // would infer a latch.
        idx           = 0;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        if (en_i) begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr_i) + k) % N;
                if (!grant_valid_o && req_i[idx]) begin
                    grant_valid_o = 1'b1;
                    grant_o[idx]  = 1'b1;
                    grant_idx_o   = IDX_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between NUM_REQ writeback
// requesters. One round-robin grant per cycle feeds a registered writeback
// stage that drives the register file; decode gets hazard flags for source
// registers with a write still in flight.
//
// Ports:
//   clk         in   1                     system clock, rising edge
//   reset       in   1                     synchronous reset, active low
//   hold        in   1                     suppress all grants while 1
//   req_valid   in   NUM_REQ               per-requester write request
//   req_addr    in   NUM_REQ*ADDR_WIDTH    packed destination addresses
//   req_data    in   NUM_REQ*DATA_WIDTH    packed write data
//   req_ready   out  NUM_REQ               one-hot grant
//   reg_write   out  1                     register file write enable
//   rd_addr     out  ADDR_WIDTH            register file destination
//   rd_data     out  DATA_WIDTH            register file write data
//   rs1_addr    in   ADDR_WIDTH            decode source 1 query
//   rs2_addr    in   ADDR_WIDTH            decode source 2 query
//   hazard_rs1  out  1                     source 1 has a pending write
//   hazard_rs2  out  1                     source 2 has a pending write
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = NUM_WB_REQ,
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          reg_write,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic [ADDR_WIDTH-1:0]         rs1_addr,
    input  logic [ADDR_WIDTH-1:0]         rs2_addr,
    output logic                          hazard_rs1,
    output logic                          hazard_rs2
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  arb_en;

    // Grants only leave the arbiter when requesters see ready, so blocking
    // them during reset guarantees no transfer is lost in reset.
    assign arb_en = reset & ~hold;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i         (req_valid),
        .ptr_i         (rr_ptr_q),
        .en_i          (arb_en),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // A grant is only issued to a valid requester, so ready alone marks
    // the transfer.
    assign req_ready = grant;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wb_valid_d = grant_valid;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (grant_valid) begin
            rr_ptr_d  = PTR_W'(rr_next(int'(grant_idx), NUM_REQ));
            wb_addr_d = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wb_data_d = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!reset) begin
            rr_ptr_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // x0 writes consume a grant but never enable the register file. The
    // enable is also gated by reset so an entry caught in the stage when
    // reset arrives is discarded instead of committing on that edge.
    assign reg_write = reset & wb_valid_q & (wb_addr_q != '0);
    assign rd_addr   = wb_addr_q;
    assign rd_data   = wb_data_q;

    // A source is hazardous while any requester is offering a write to it
    // or the writeback stage holds one. Independent of hold.
    always_comb begin
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == rs1_addr) hazard_rs1 = 1'b1;
                if (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == rs2_addr) hazard_rs2 = 1'b1;
            end
        end
        if (wb_valid_q && wb_addr_q == rs1_addr) hazard_rs1 = 1'b1;
        if (wb_valid_q && wb_addr_q == rs2_addr) hazard_rs2 = 1'b1;
        if (rs1_addr == '0) hazard_rs1 = 1'b0;
        if (rs2_addr == '0) hazard_rs2 = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed scenarios followed by randomized traffic. A reference model
// (pending-write list, round-robin search over a plain integer pointer)
// evaluates grants and hazards mid-cycle and queues the expected writeback;
// a separate monitor pops that queue and compares the register-file port.
// A shadow register file fed by the DUT is compared with the model's one.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               hold;
    logic [NR-1:0]      req_valid;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic               reg_write;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_data;
    logic [AW-1:0]      rs1_addr;
    logic [AW-1:0]      rs2_addr;
    logic               hazard_rs1;
    logic               hazard_rs2;

    regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .hazard_rs1 (hazard_rs1),
        .hazard_rs2 (hazard_rs2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    wb_t           exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    // Model state
    int            m_ptr = 0;
    bit            m_prev_xfer = 1'b0;
    logic [AW-1:0] m_prev_addr = '0;
    logic [DW-1:0] m_prev_data = '0;
    logic [DW-1:0] m_rf [32];
    logic [DW-1:0] rf_tb [32];
    logic [NR-1:0] dut_acc = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Shadow register file written by the DUT's port; x0 stays zero.
    always @(posedge clk) begin
        if (reg_write && rd_addr != '0) rf_tb[rd_addr] <= rd_data;
    end

    function automatic bit pending(input logic [AW-1:0] rs);
        if (rs == '0) return 1'b0;
        for (int i = 0; i < NR; i++)
            if (req_valid[i] && req_addr[i*AW +: AW] == rs) return 1'b1;
        if (m_prev_xfer && m_prev_addr == rs) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model, evaluated mid-cycle on settled inputs.
    always @(negedge clk) begin : model
        logic [NR-1:0] exp_ready;
        int            g;
        check("hazard_rs1", hazard_rs1, pending(rs1_addr));
        check("hazard_rs2", hazard_rs2, pending(rs2_addr));

        // Last cycle's transfer is on the port now; a reset this cycle kills it.
        if (m_prev_xfer && reset) begin
            exp_q.push_back('{we: (m_prev_addr != '0), addr: m_prev_addr, data: m_prev_data});
            if (m_prev_addr != '0) m_rf[m_prev_addr] = m_prev_data;
        end

        exp_ready = '0;
        g = -1;
        if (reset && !hold) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);

        m_prev_xfer = (g >= 0);
        if (g >= 0) begin
            m_prev_addr = req_addr[g*AW +: AW];
            m_prev_data = req_data[g*DW +: DW];
        end
        if (!reset) m_ptr = 0;
        else if (g >= 0) m_ptr = (g + 1) % NR;
        dut_acc = req_valid & req_ready;
    end

    // Monitor: compares the register-file port against queued expectations.
    always @(negedge clk) begin : monitor
        wb_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("reg_write", reg_write, e.we);
            check("rd_addr", rd_addr, e.addr);
            check("rd_data", rd_data, e.data);
        end else begin
            check("reg_write_idle", reg_write, 1'b0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]       = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic rand_step();
        hold     = ($urandom_range(0, 9) == 0);
        reset    = ($urandom_range(0, 29) != 0);
        rs1_addr = AW'($urandom_range(0, 7));
        rs2_addr = AW'($urandom_range(0, 7));
        for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] || dut_acc[i])
                set_req(i, ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_rf[r]  = '0;
            rf_tb[r] = '0;
        end
        // Reset with both requesters valid: nothing may be granted.
        reset = 1'b0; hold = 1'b0; rs1_addr = 5'd2; rs2_addr = 5'd3;
        req_valid = '0; req_addr = '0; req_data = '0;
        set_req(0, 1'b1, 5'd2, 32'h8765_4321);
        set_req(1, 1'b1, 5'd3, 32'h0000_BEEF);
        cycle();
        cycle();
        check("reset_reg_write", reg_write, 1'b0);
        check("reset_rd_addr", rd_addr, 5'd0);
        check("reset_rd_data", rd_data, 32'd0);

        // Release: continuous contention, grants alternate starting at 0.
        reset = 1'b1;
        repeat (4) cycle();

        // Single write to x1.
        req_valid = '0;
        set_req(0, 1'b1, 5'd1, 32'h1234_5678);
        rs1_addr = 5'd1; rs2_addr = 5'd0;
        cycle();
        req_valid = '0;
        cycle();
        check("rf_x1", rf_tb[1], 32'h1234_5678);

        // x0 write is accepted but never enables the register file.
        set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        cycle();
        req_valid = '0;
        cycle();

        // Hazard on x5 through request, then writeback stage, then clear.
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        set_req(0, 1'b1, 5'd5, 32'hA5A5_0005);
        cycle();
        req_valid = '0;
        repeat (2) cycle();

        // Hold with a pending request, then grant req0, req1, reset mid-flight.
        hold = 1'b1;
        set_req(0, 1'b1, 5'd6, 32'h0000_0066);
        repeat (3) cycle();
        hold = 1'b0;
        cycle();
        req_valid = '0;
        set_req(1, 1'b1, 5'd7, 32'h0000_0077);
        cycle();
        req_valid = '0;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();

        // Randomized traffic with occasional hold and reset.
        repeat (400) begin
            rand_step();
            cycle();
        end

        // Drain and compare register file contents.
        reset = 1'b1; hold = 1'b0; req_valid = '0;
        repeat (3) cycle();
        for (int r = 1; r < 32; r++) check($sformatf("rf_x%0d", r), rf_tb[r], m_rf[r]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
